// File: rtl/ivt_port_arbiter_if.sv
// Port-A sharing interface for the IVT arbiter: vector-fetch requester, Wishbone
// classic slave, and the RAM port itself. The arbiter takes the slave modport.
interface ivt_port_arbiter_if #(
    parameter int unsigned AWID = 13
);
    logic            vf_req_i;
    logic [AWID-1:0] vf_adr_i;
    logic            vf_ack_o;
    logic [31:0]     vf_dat_o;

    logic            cyc_i;
    logic            stb_i;
    logic            we_i;
    logic [3:0]      sel_i;
    logic [AWID-1:0] adr_i;
    logic [31:0]     dat_i;
    logic            ack_o;
    logic [31:0]     dat_o;

    logic            ram_en_o;
    logic [3:0]      ram_we_o;
    logic [AWID-1:0] ram_adr_o;
    logic [31:0]     ram_dat_o;
    logic [31:0]     ram_dat_i;

    logic            busy_o;

    modport slave (
        input  vf_req_i, vf_adr_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, ram_dat_i,
        output vf_ack_o, vf_dat_o, ack_o, dat_o,
        output ram_en_o, ram_we_o, ram_adr_o, ram_dat_o, busy_o
    );

    modport master (
        output vf_req_i, vf_adr_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, ram_dat_i,
        input  vf_ack_o, vf_dat_o, ack_o, dat_o,
        input  ram_en_o, ram_we_o, ram_adr_o, ram_dat_o, busy_o
    );
endinterface

// File: rtl/ivt_port_arbiter.sv
// Arbitrates IVT RAM port A between vector fetch and a Wishbone slave, one transfer at a time.
// Optional post-reset table clear is enabled with `define IVT_INIT_EN.
module ivt_port_arbiter #(
    parameter int unsigned AWID        = 13,
    parameter int unsigned DEPTH       = 8192,
    parameter int unsigned RD_LAT      = 2,
    parameter logic [31:0] DEFAULT_VEC = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ivt_port_arbiter_if.slave arb
);

    if (RD_LAT < 1 || RD_LAT > 3 || DEPTH < 1 || DEPTH > (32'd1 << AWID)
        || $bits(DEFAULT_VEC) != 32) begin : g_bad_params
        $error("ivt_port_arbiter: RD_LAT must be 1..3 and DEPTH must fit in AWID");
    end

    typedef enum logic [2:0] {INIT, IDLE, RDW, WR, ACK} state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

`ifdef IVT_INIT_EN
    localparam state_t          RESET_STATE = INIT;
    localparam logic [AWID-1:0] INIT_LAST   = AWID'(DEPTH - 1);
`else
    localparam state_t          RESET_STATE = IDLE;
`endif

    // Registered copies of the requester inputs; grant decisions use only these.
    logic            vf_req_reg;
    logic [AWID-1:0] vf_adr_reg;
    logic            bus_req_reg;
    logic            we_reg;
    logic [3:0]      sel_reg;
    logic [AWID-1:0] adr_reg;
    logic [31:0]     wdat_reg;

    state_t          state_reg,   state_next;
    logic [1:0]      cnt_reg,     cnt_next;
    logic            gnt_vf_reg,  gnt_vf_next;
    logic            last_vf_reg, last_vf_next;
    logic            vf_ack_reg,  vf_ack_next;
    logic            ack_reg,     ack_next;
    logic [31:0]     vf_rdat_reg, vf_rdat_next;
    logic [31:0]     rdat_reg,    rdat_next;

    logic            ram_en;
    logic [3:0]      ram_we;
    logic [AWID-1:0] ram_adr;
    logic [31:0]     ram_dat;
    logic            pick_vf;

`ifdef IVT_INIT_EN
    logic [AWID-1:0] init_cnt_reg, init_cnt_next;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vf_req_reg  <= 1'b0;
            vf_adr_reg  <= '0;
            bus_req_reg <= 1'b0;
            we_reg      <= 1'b0;
            sel_reg     <= 4'h0;
            adr_reg     <= '0;
            wdat_reg    <= 32'h0;
        end else begin
            vf_req_reg  <= arb.vf_req_i;
            vf_adr_reg  <= arb.vf_adr_i;
            bus_req_reg <= arb.cyc_i & arb.stb_i;
            we_reg      <= arb.we_i;
            sel_reg     <= arb.sel_i;
            adr_reg     <= arb.adr_i;
            wdat_reg    <= arb.dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= RESET_STATE;
            cnt_reg     <= 2'd0;
            gnt_vf_reg  <= 1'b0;
            last_vf_reg <= 1'b0;
            vf_ack_reg  <= 1'b0;
            ack_reg     <= 1'b0;
            vf_rdat_reg <= 32'h0;
            rdat_reg    <= 32'h0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            gnt_vf_reg  <= gnt_vf_next;
            last_vf_reg <= last_vf_next;
            vf_ack_reg  <= vf_ack_next;
            ack_reg     <= ack_next;
            vf_rdat_reg <= vf_rdat_next;
            rdat_reg    <= rdat_next;
        end
    end

`ifdef IVT_INIT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_cnt_reg <= '0;
        end else begin
            init_cnt_reg <= init_cnt_next;
        end
    end
`endif

    // Under contention the requester that did not win last time gets the port.
    assign pick_vf = vf_req_reg & (~bus_req_reg | ~last_vf_reg);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        gnt_vf_next  = gnt_vf_reg;
        last_vf_next = last_vf_reg;
        vf_ack_next  = 1'b0;
        ack_next     = 1'b0;
        vf_rdat_next = vf_rdat_reg;
        rdat_next    = rdat_reg;
        ram_en       = 1'b0;
        ram_we       = 4'h0;
        ram_adr      = '0;
        ram_dat      = 32'h0;
`ifdef IVT_INIT_EN
        init_cnt_next = init_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (vf_req_reg || bus_req_reg) begin
                    ram_en       = 1'b1;
                    gnt_vf_next  = pick_vf;
                    last_vf_next = pick_vf;
                    cnt_next     = 2'd0;
                    if (pick_vf) begin
                        ram_adr    = vf_adr_reg;
                        state_next = RDW;
                    end else begin
                        ram_adr = adr_reg;
                        if (we_reg) begin
                            // Write acks the cycle after the grant; ACK state follows silently.
                            ram_we     = sel_reg;
                            ram_dat    = wdat_reg;
                            ack_next   = 1'b1;
                            state_next = WR;
                        end else begin
                            state_next = RDW;
                        end
                    end
                end
            end
            RDW: begin
                if (cnt_reg == LAT_LAST) begin
                    if (gnt_vf_reg) begin
                        vf_rdat_next = arb.ram_dat_i;
                        vf_ack_next  = 1'b1;
                    end else begin
                        rdat_next = arb.ram_dat_i;
                        ack_next  = 1'b1;
                    end
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            WR:  state_next = ACK;
            ACK: state_next = IDLE;
            INIT: begin
`ifdef IVT_INIT_EN
                ram_en  = 1'b1;
                ram_we  = 4'hF;
                ram_adr = init_cnt_reg;
                ram_dat = DEFAULT_VEC;
                if (init_cnt_reg == INIT_LAST) begin
                    init_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign arb.vf_ack_o  = vf_ack_reg;
    assign arb.vf_dat_o  = vf_rdat_reg;
    assign arb.ack_o     = ack_reg;
    assign arb.dat_o     = rdat_reg;
    assign arb.ram_en_o  = ram_en;
    assign arb.ram_we_o  = ram_we;
    assign arb.ram_adr_o = ram_adr;
    assign arb.ram_dat_o = ram_dat;

`ifdef IVT_INIT_EN
    assign arb.busy_o = (state_reg == INIT);
`else
    assign arb.busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_ivt_port_arbiter.sv
// Self-checking bench for ivt_port_arbiter: behavioural RAM with RD_LAT latency,
// reference memory model and expected-data queues.
module tb_ivt_port_arbiter;

    localparam int unsigned AWID   = 13;
    localparam int unsigned RD_LAT = 2;
`ifdef IVT_INIT_EN
    localparam bit          INIT_EN     = 1'b1;
    localparam int unsigned DEPTH       = 16;
    localparam logic [31:0] DEFAULT_VEC = 32'h0000_0400;
`else
    localparam bit          INIT_EN     = 1'b0;
    localparam int unsigned DEPTH       = 8192;
    localparam logic [31:0] DEFAULT_VEC = 32'h0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [int unsigned];

    ivt_port_arbiter_if #(.AWID(AWID)) bus_if ();

    ivt_port_arbiter #(
        .AWID(AWID), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .DEFAULT_VEC(DEFAULT_VEC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .arb  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural port-A RAM: byte-lane writes, RD_LAT-deep read pipeline.
    logic [31:0] mem [0:(1<<AWID)-1];
    logic [31:0] rd_pipe [0:2];
    always @(posedge clk) begin
        if (bus_if.ram_en_o) begin
            for (int b = 0; b < 4; b++)
                if (bus_if.ram_we_o[b]) mem[bus_if.ram_adr_o][b*8 +: 8] <= bus_if.ram_dat_o[b*8 +: 8];
            rd_pipe[0] <= mem[bus_if.ram_adr_o];
        end
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign bus_if.ram_dat_i = rd_pipe[RD_LAT-1];

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // Drives one bus transfer from a negedge; lat = ack cycle minus grant cycle.
    task automatic bus_xfer(input logic wr, input logic [3:0] sel, input logic [AWID-1:0] adr,
                            input logic [31:0] wdat, output logic [31:0] rdat,
                            output int lat, output bit got);
        int t;
        t = -1; lat = -1; got = 1'b0; rdat = 32'h0;
        bus_if.cyc_i = 1'b1; bus_if.stb_i = 1'b1; bus_if.we_i = wr;
        bus_if.sel_i = sel; bus_if.adr_i = adr; bus_if.dat_i = wdat;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (t < 0 && bus_if.ram_en_o && bus_if.ram_adr_o == adr) t = n;
            if (bus_if.ack_o) begin
                got = 1'b1; rdat = bus_if.dat_o; lat = n - t;
                break;
            end
        end
        bus_if.cyc_i = 1'b0; bus_if.stb_i = 1'b0; bus_if.we_i = 1'b0;
    endtask

    task automatic vf_xfer(input logic [AWID-1:0] adr, output logic [31:0] rdat,
                           output int lat, output bit got);
        int t;
        t = -1; lat = -1; got = 1'b0; rdat = 32'h0;
        bus_if.vf_req_i = 1'b1; bus_if.vf_adr_i = adr;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (t < 0 && bus_if.ram_en_o && bus_if.ram_adr_o == adr) t = n;
            if (bus_if.vf_ack_o) begin
                got = 1'b1; rdat = bus_if.vf_dat_o; lat = n - t;
                break;
            end
        end
        bus_if.vf_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus_if.ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b want=0", bus_if.ack_o); end
        n_cmp++; if (bus_if.vf_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_vf_ack got=%b want=0", bus_if.vf_ack_o); end
        n_cmp++; if (bus_if.dat_o !== 32'h0) begin n_err++; $display("FAIL reset_dat got=%h want=0", bus_if.dat_o); end
        n_cmp++; if (bus_if.vf_dat_o !== 32'h0) begin n_err++; $display("FAIL reset_vf_dat got=%h want=0", bus_if.vf_dat_o); end
        n_cmp++; if (bus_if.ram_en_o !== INIT_EN) begin n_err++; $display("FAIL reset_ram_en got=%b want=%b", bus_if.ram_en_o, INIT_EN); end
        n_cmp++; if (bus_if.busy_o !== INIT_EN) begin n_err++; $display("FAIL reset_busy got=%b want=%b", bus_if.busy_o, INIT_EN); end
        $display("reset: ack=%b vf_ack=%b ram_en=%b busy=%b", bus_if.ack_o, bus_if.vf_ack_o, bus_if.ram_en_o, bus_if.busy_o);
    endtask

    task automatic test_init();
        int busy_n;
        bit early_ack;
        bit got;
        logic [31:0] exp_v;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = DEFAULT_VEC;
        bus_if.cyc_i = 1'b1; bus_if.stb_i = 1'b1; bus_if.we_i = 1'b0;
        bus_if.sel_i = 4'hF; bus_if.adr_i = 13'h00F;
        exp_q.push_back(ref_mem[15]);
        rst = 1'b0;
        busy_n = 0; early_ack = 1'b0;
        while (bus_if.busy_o === 1'b1 && busy_n < 100) begin
            busy_n++;
            if (bus_if.ack_o) early_ack = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (busy_n != int'(DEPTH)) begin n_err++; $display("FAIL init_busy_len got=%0d want=%0d", busy_n, DEPTH); end
        n_cmp++; if (early_ack !== 1'b0) begin n_err++; $display("FAIL init_early_ack got=%b want=0", early_ack); end
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus_if.ack_o) begin got = 1'b1; break; end
            @(negedge clk);
        end
        exp_v = exp_q.pop_front();
        n_cmp++; if (!got) begin n_err++; $display("FAIL init_read_ack got=timeout want=ack"); end
        n_cmp++; if (bus_if.dat_o !== exp_v) begin n_err++; $display("FAIL init_read_dat got=%h want=%h", bus_if.dat_o, exp_v); end
        $display("init: busy_cycles=%0d read 00F dat=%h", busy_n, bus_if.dat_o);
        bus_if.cyc_i = 1'b0; bus_if.stb_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bus_rw();
        logic [31:0] d, exp_v;
        int lat;
        bit got;
        ref_mem[13'h010] = merge(ref_mem.exists(13'h010) ? ref_mem[13'h010] : 32'h0, 32'hDEAD_BEEF, 4'hF);
        bus_xfer(1'b1, 4'hF, 13'h010, 32'hDEAD_BEEF, d, lat, got);
        n_cmp++; if (!got) begin n_err++; $display("FAIL wr_ack got=timeout want=ack"); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL wr_latency got=%0d want=1", lat); end
        $display("bus write adr=010 dat=deadbeef lat=%0d", lat);
        exp_q.push_back(ref_mem[13'h010]);
        bus_xfer(1'b0, 4'h0, 13'h010, 32'h0, d, lat, got);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!got) begin n_err++; $display("FAIL rd_ack got=timeout want=ack"); end
        n_cmp++; if (lat != int'(RD_LAT) + 1) begin n_err++; $display("FAIL rd_latency got=%0d want=%0d", lat, RD_LAT + 1); end
        n_cmp++; if (d !== exp_v) begin n_err++; $display("FAIL rd_dat got=%h want=%h", d, exp_v); end
        $display("bus read adr=010 dat=%h lat=%0d", d, lat);
        @(negedge clk);
        n_cmp++; if (bus_if.ack_o !== 1'b0) begin n_err++; $display("FAIL ack_pulse got=%b want=0", bus_if.ack_o); end
        n_cmp++; if (bus_if.dat_o !== exp_v) begin n_err++; $display("FAIL dat_held got=%h want=%h", bus_if.dat_o, exp_v); end
    endtask

    task automatic test_vf_read();
        logic [31:0] d, exp_v;
        int lat;
        bit got;
        exp_q.push_back(ref_mem[13'h010]);
        vf_xfer(13'h010, d, lat, got);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!got) begin n_err++; $display("FAIL vf_ack got=timeout want=ack"); end
        n_cmp++; if (lat != int'(RD_LAT) + 1) begin n_err++; $display("FAIL vf_latency got=%0d want=%0d", lat, RD_LAT + 1); end
        n_cmp++; if (d !== exp_v) begin n_err++; $display("FAIL vf_dat got=%h want=%h", d, exp_v); end
        $display("vf read adr=010 dat=%h lat=%0d", d, lat);
        @(negedge clk);
    endtask

    task automatic test_byte_sel();
        logic [31:0] d, exp_v;
        int lat;
        bit got;
        ref_mem[13'h010] = merge(ref_mem[13'h010], 32'h0000_AB00, 4'b0010);
        bus_xfer(1'b1, 4'b0010, 13'h010, 32'h0000_AB00, d, lat, got);
        n_cmp++; if (!got) begin n_err++; $display("FAIL sel_wr_ack got=timeout want=ack"); end
        exp_q.push_back(ref_mem[13'h010]);
        bus_xfer(1'b0, 4'h0, 13'h010, 32'h0, d, lat, got);
        exp_v = exp_q.pop_front();
        n_cmp++; if (d !== exp_v) begin n_err++; $display("FAIL sel_rd_dat got=%h want=%h", d, exp_v); end
        $display("byte-lane write sel=2 readback=%h", d);
        // sel=0: acked, nothing written
        ref_mem[13'h010] = merge(ref_mem[13'h010], 32'h1234_5678, 4'h0);
        bus_xfer(1'b1, 4'h0, 13'h010, 32'h1234_5678, d, lat, got);
        n_cmp++; if (!got || lat != 1) begin n_err++; $display("FAIL sel0_ack got=%0b/%0d want=1/1", got, lat); end
        exp_q.push_back(ref_mem[13'h010]);
        bus_xfer(1'b0, 4'h0, 13'h010, 32'h0, d, lat, got);
        exp_v = exp_q.pop_front();
        n_cmp++; if (d !== exp_v) begin n_err++; $display("FAIL sel0_rd_dat got=%h want=%h", d, exp_v); end
        $display("sel=0 write readback=%h", d);
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [AWID-1:0] grants[$];
        logic [AWID-1:0] exp_g[$];
        logic [31:0] exp_vf_q[$];
        logic [31:0] exp_bus_q[$];
        logic [31:0] d, exp_v;
        logic [AWID-1:0] g;
        int lat, overlap, vf_n, bus_n;
        bit got;
        ref_mem[13'h020] = 32'hCAFE_0020;
        bus_xfer(1'b1, 4'hF, 13'h020, 32'hCAFE_0020, d, lat, got);
        @(negedge clk);
        exp_g = '{13'h010, 13'h020, 13'h010, 13'h020};
        overlap = 0; vf_n = 0; bus_n = 0;
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    exp_vf_q.push_back(ref_mem[13'h010]);
                    bus_if.vf_req_i = 1'b1; bus_if.vf_adr_i = 13'h010;
                    for (int n = 0; n < 30; n++) begin
                        @(negedge clk);
                        if (bus_if.vf_ack_o) begin
                            vf_n++;
                            exp_v = exp_vf_q.pop_front();
                            n_cmp++; if (bus_if.vf_dat_o !== exp_v) begin n_err++; $display("FAIL cont_vf_dat got=%h want=%h", bus_if.vf_dat_o, exp_v); end
                            break;
                        end
                    end
                    bus_if.vf_req_i = 1'b0;
                    @(negedge clk);
                end
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    exp_bus_q.push_back(ref_mem[13'h020]);
                    bus_if.cyc_i = 1'b1; bus_if.stb_i = 1'b1; bus_if.we_i = 1'b0; bus_if.adr_i = 13'h020;
                    for (int n = 0; n < 30; n++) begin
                        @(negedge clk);
                        if (bus_if.ack_o) begin
                            bus_n++;
                            exp_v = exp_bus_q.pop_front();
                            n_cmp++; if (bus_if.dat_o !== exp_v) begin n_err++; $display("FAIL cont_bus_dat got=%h want=%h", bus_if.dat_o, exp_v); end
                            break;
                        end
                    end
                    bus_if.cyc_i = 1'b0; bus_if.stb_i = 1'b0;
                    @(negedge clk);
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    @(negedge clk);
                    if (bus_if.ram_en_o) grants.push_back(bus_if.ram_adr_o);
                    if (bus_if.vf_ack_o && bus_if.ack_o) overlap++;
                end
            end
        join
        n_cmp++; if (vf_n != 2 || bus_n != 2) begin n_err++; $display("FAIL cont_acks got=%0d/%0d want=2/2", vf_n, bus_n); end
        n_cmp++; if (overlap != 0) begin n_err++; $display("FAIL cont_overlap got=%0d want=0", overlap); end
        n_cmp++; if (grants.size() != 4) begin n_err++; $display("FAIL cont_grant_count got=%0d want=4", grants.size()); end
        for (int i = 0; i < 4 && grants.size() > 0; i++) begin
            g = grants.pop_front();
            n_cmp++; if (g !== exp_g[i]) begin n_err++; $display("FAIL cont_grant%0d got=%h want=%h", i, g, exp_g[i]); end
            $display("contention grant %0d adr=%h", i, g);
        end
    endtask

    task automatic test_reset_in_rdw();
        logic [31:0] d, exp_v;
        int lat, spurious;
        bit got, granted;
        bus_if.cyc_i = 1'b1; bus_if.stb_i = 1'b1; bus_if.we_i = 1'b0; bus_if.adr_i = 13'h010;
        granted = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus_if.ram_en_o) begin granted = 1'b1; break; end
        end
        n_cmp++; if (!granted) begin n_err++; $display("FAIL rst_pre_grant got=timeout want=grant"); end
        @(negedge clk);
        rst = 1'b1; bus_if.cyc_i = 1'b0; bus_if.stb_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus_if.ack_o !== 1'b0 || bus_if.vf_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_rdw_ack got=%b%b want=00", bus_if.ack_o, bus_if.vf_ack_o); end
        n_cmp++; if (bus_if.dat_o !== 32'h0 || bus_if.vf_dat_o !== 32'h0) begin n_err++; $display("FAIL rst_rdw_dat got=%h/%h want=0/0", bus_if.dat_o, bus_if.vf_dat_o); end
        n_cmp++; if (bus_if.ram_en_o !== INIT_EN) begin n_err++; $display("FAIL rst_rdw_ram_en got=%b want=%b", bus_if.ram_en_o, INIT_EN); end
        rst = 1'b0;
        spurious = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus_if.ack_o || bus_if.vf_ack_o) spurious++;
        end
        n_cmp++; if (spurious != 0) begin n_err++; $display("FAIL rst_rdw_spurious got=%0d want=0", spurious); end
        exp_q.push_back(ref_mem[13'h010]);
        bus_xfer(1'b0, 4'h0, 13'h010, 32'h0, d, lat, got);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!got) begin n_err++; $display("FAIL rst_fresh_ack got=timeout want=ack"); end
        n_cmp++; if (d !== exp_v) begin n_err++; $display("FAIL rst_fresh_dat got=%h want=%h", d, exp_v); end
        $display("reset in RDW: spurious=%0d fresh read dat=%h", spurious, d);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        bus_if.vf_req_i = 1'b0; bus_if.vf_adr_i = '0;
        bus_if.cyc_i = 1'b0; bus_if.stb_i = 1'b0; bus_if.we_i = 1'b0;
        bus_if.sel_i = 4'h0; bus_if.adr_i = '0; bus_if.dat_i = 32'h0;
        test_reset();
`ifdef IVT_INIT_EN
        test_init();
`else
        rst = 1'b0;
        @(negedge clk);
`endif
        test_bus_rw();
        test_vf_read();
        test_byte_sel();
        test_contention();
        test_reset_in_rdw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
